sps_host_driver: RTL

Host-side initiator for the SPS burst serial MRAM interface. It accepts one parallel command at a time, serialises its 20-bit address and 16-bit write data into the control/shift-register path in lock-step with the 23-cycle controller frame, and drives `read_write_sel`. For reads, it deserialises the word returned serially on the following frame and presents it as a parallel response.

---
 rtl/sps_host_driver_if.sv | 25 ++
 rtl/sps_host_driver.sv | 137 +++++++++++++
 2 files changed

// File: rtl/sps_host_driver_if.sv
// Parallel command/response port of the SPS host driver.
// The host side uses master; the driver uses slave.
interface sps_host_driver_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/sps_host_driver.sv
// SPS host driver: serialises one command per controller frame and
// deserialises the read word returned on the following frame.
module sps_host_driver #(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 23
) (
    input  logic            clk,
    input  logic            rst,
    sps_host_driver_if.slave host,
    output logic [2:0]      read_write_sel,
    output logic            serial_addr,
    output logic            serial_data,
    input  logic            serial_rdata
);
    localparam int FC_W = $clog2(FRAME_LEN);
    localparam int HALF = DATA_W / 2;
    localparam logic [FC_W-1:0] FC_LAST   = FC_W'(FRAME_LEN - 1);
    localparam logic [FC_W-1:0] SER_FIRST = FC_W'(2);
    localparam logic [FC_W-1:0] A_LAST    = FC_W'(ADDR_W + 1);
    localparam logic [FC_W-1:0] D_LAST    = FC_W'(DATA_W + 1);
    localparam logic [FC_W-1:0] R_FIRST   = FC_W'(3);
    localparam logic [FC_W-1:0] R_FULL    = FC_W'(DATA_W + 2);
    localparam logic [FC_W-1:0] R_HALF    = FC_W'(HALF + 2);

    typedef enum logic [1:0] {IDLE, SYNC, XFER, RET} state_t;

    state_t            state_q, state_d;
    logic [FC_W-1:0]   fc_q, fc_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [2:0]        rws_q, rws_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic              full_word;
    logic              wr_bytes;
    logic              addr_act;
    logic              data_act;
    logic [FC_W-1:0]   r_last;
    logic [DATA_W-1:0] sh_next;

    assign full_word = (op_q[2:1] == 2'b11);
    assign wr_bytes  = op_q[0] && (op_q[2:1] != 2'b00);
    assign r_last    = full_word ? R_FULL : R_HALF;
    assign sh_next   = {sh_q[DATA_W-2:0], serial_rdata};
    assign addr_act  = (state_q == XFER) && (fc_q >= SER_FIRST) && (fc_q <= A_LAST);
    assign data_act  = (state_q == XFER) && wr_bytes && (fc_q >= SER_FIRST) && (fc_q <= D_LAST);

    // Address and data registers double as shift registers: MSB is on the wire.
    assign serial_addr    = addr_act ? addr_q[ADDR_W-1] : 1'b0;
    assign serial_data    = data_act ? wdata_q[DATA_W-1] : 1'b0;
    assign read_write_sel = rws_q;

    assign host.cmd_ready = (state_q == IDLE);
    assign host.busy      = (state_q != IDLE);
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_data  = rsp_data_q;

    always_comb begin
        state_d     = state_q;
        fc_d        = (fc_q == FC_LAST) ? '0 : fc_q + FC_W'(1);
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        sh_d        = sh_q;
        rws_d       = rws_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            IDLE: begin
                rws_d = 3'b000;
                if (host.cmd_valid) begin
                    op_d    = host.cmd_op;
                    addr_d  = host.cmd_addr;
                    wdata_d = host.cmd_wdata;
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (fc_q == FC_LAST) begin
                    rws_d   = op_q;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (addr_act) addr_d  = addr_q << 1;
                if (data_act) wdata_d = wdata_q << 1;
                if (fc_q == FC_LAST) begin
                    rws_d   = 3'b000;
                    state_d = (!op_q[0] && (op_q[2:1] != 2'b00)) ? RET : IDLE;
                end
            end
            RET: begin
                if ((fc_q >= R_FIRST) && (fc_q <= r_last)) sh_d = sh_next;
                // Response registers on the last sampled bit, so it shows one cycle later.
                if (fc_q == r_last) begin
                    rsp_valid_d = 1'b1;
                    if (full_word)
                        rsp_data_d = sh_next;
                    else if (op_q[2])
                        rsp_data_d = {sh_next[HALF-1:0], {HALF{1'b0}}};
                    else
                        rsp_data_d = {{HALF{1'b0}}, sh_next[HALF-1:0]};
                end
                if (fc_q == FC_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            fc_q        <= '0;
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            sh_q        <= '0;
            rws_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            fc_q        <= fc_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            sh_q        <= sh_d;
            rws_q       <= rws_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end
endmodule
